div_share_arbiter: RTL

//  Shares one external sequential divider (div, start/done_tick handshake) among N requesters.

---
 rtl/div_share_arbiter_pkg.sv | 17 +
 rtl/div_share_arbiter_rr_pick.sv | 30 +++
 rtl/div_share_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/div_share_arbiter_pkg.sv
// Shared types and helpers for the divider-sharing arbiter.
package div_share_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Index width for N ports, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Round-robin pick: first pending port after ptr, scanning ptr+1, ptr+2, ... modulo N.
module div_share_arbiter_rr_pick
  import div_share_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  pending_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] grant_o,
  output logic          any_o
);

  int idx;

  // Walk the rotation backwards so the nearest port after ptr overwrites the rest.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (pending_i[idx]) begin
        grant_o = PW'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one start/done sequential divider among N requesters with round-robin grant.
module div_share_arbiter
  import div_share_arbiter_pkg::*;
#(
  parameter  int W  = 30,
  parameter  int N  = 2,
  localparam int OW = clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req_tick,
  input  logic [N*W-1:0] req_dvnd,
  input  logic [N*W-1:0] req_dvsr,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   ovr_tick,
  output logic [N-1:0]   done_tick,
  output logic [W-1:0]   quo,
  output logic [W-1:0]   rmd,
  output logic [OW-1:0]  owner,
  output logic           busy,
  output logic           div_start,
  output logic [W-1:0]   div_dvnd,
  output logic [W-1:0]   div_dvsr,
  input  logic [W-1:0]   div_quo,
  input  logic [W-1:0]   div_rmd,
  input  logic           div_done_tick
);

  logic [N-1:0][W-1:0] dvnd_q, dvsr_q;
  logic [N-1:0]        pending_q, done_q, cap, clr;
  logic [OW-1:0]       owner_q, ptr_q, pick;
  logic [W-1:0]        quo_q, rmd_q;
  logic                pick_vld, finish;
  state_e              state_q;

  div_share_arbiter_rr_pick #(.N(N), .PW(OW)) u_rr_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .grant_o   (pick),
    .any_o     (pick_vld)
  );

  // A port stays pending through its completion cycle, so a tick there is dropped.
  assign cap    = req_tick & ~pending_q;
  assign finish = (state_q == WAIT) && div_done_tick;

  always_comb begin
    clr = '0;
    if (finish) clr[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvnd_q <= '0;
      dvsr_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          dvnd_q[i] <= req_dvnd[i*W +: W];
          dvsr_q[i] <= req_dvsr[i*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= '0;
      owner_q   <= '0;
      ptr_q     <= OW'(N-1);
      quo_q     <= '0;
      rmd_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | cap;
      done_q    <= clr;
      case (state_q)
        IDLE: if (pick_vld) begin
          owner_q <= pick;
          state_q <= WAIT;
        end
        WAIT: if (div_done_tick) begin
          quo_q   <= div_quo;
          rmd_q   <= div_rmd;
          ptr_q   <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Start is asserted from idle so operands are muxed from the pick, not the owner.
  assign div_start = (state_q == IDLE) && pick_vld;

  always_comb begin
    div_dvnd = '0;
    div_dvsr = '0;
    if (state_q == WAIT) begin
      div_dvnd = dvnd_q[owner_q];
      div_dvsr = dvsr_q[owner_q];
    end else if (div_start) begin
      div_dvnd = dvnd_q[pick];
      div_dvsr = dvsr_q[pick];
    end
  end

  assign req_ready = ~pending_q;
  assign ovr_tick  = req_tick & pending_q;
  assign done_tick = done_q;
  assign quo       = quo_q;
  assign rmd       = rmd_q;
  assign owner     = owner_q;
  assign busy      = (state_q == WAIT);

endmodule
